fp_add_sub: RTL and testbench
=============================

// Module: fp_add_sub
// PURPOSE
//   Pipelined IEEE-754 binary32 adder/subtractor. Computes S = A + B or S = A - B.
//   Used as the magnitude comparator inside max-pool: the sign of A-B selects the
//   larger operand. Also serves as the general FP adder for conv/dense datapaths.
// PARAMETERS
//   EXP_W  8   exponent width
//   MAN_W  23  stored mantissa width
//   BIT    32  word width; must equal 1+EXP_W+MAN_W
// PORTS
//   clk         in   1    clock, rising edge
//   rst_        in   1    asynchronous reset, active low
//   in_valid    in   1    A/B/add_or_sub are sampled when high
//   A           in   BIT  operand A (sign|exp|mantissa)
//   B           in   BIT  operand B
//   add_or_sub  in   1    0: A+B; 1: A-B (B sign inverted)
//   S           out  BIT  result
//   out_valid   out  1    S carries a new result this cycle
// BEHAVIOUR
// - Reset (async, rst_=0): S=0, out_valid=0, all stage valid bits cleared.
// - Reset mid-operation discards in-flight results. No output for them after release.
// - Fully pipelined, 3 stages, latency 3:
//   - An operation sampled at edge N appears on S/out_valid after edge N+3.
//   - Accepts one operation per cycle. No stall, no backpressure.
// - Pipeline stages:
//   - stage1: unpack, effective op, swap so |X|>=|Y|, align Y by the exponent difference.
//     Bits shifted out OR into a sticky bit. Shift >= MAN_W+3 leaves only the sticky bit.
//   - stage2: add/subtract 27-bit significands (hidden|man|G|R|S).
//   - stage3: normalize with leading-zero count, round, pack.
// - Rounding: round-to-nearest, ties-to-even.
// - Mantissa carry-out of rounding increments the exponent.
// - S holds its last value while out_valid=0.
// - Result sign:
//   - Nonzero result takes the sign of the larger-magnitude effective operand.
//   - Exact-zero result of opposite-sign operands is +0, so A-B with A==B gives 0x00000000.
//   - (-0)+(-0) and (-0)-(+0) give -0.
// - Special values:
//   - Any NaN input -> 0x7FC00000.
//   - Inf-Inf with effective subtraction -> 0x7FC00000.
//   - Inf op finite -> that Inf.
//   - Overflow after rounding -> +/-Inf (0x7F800000 / 0xFF800000).
// - Underflow: handled per CONFIGURATION. No exception flags are produced.
// CONFIGURATION
//   FP_ADD_SUB_SUBNORMAL_EN
//   - Defined: full gradual underflow.
//     - Subnormal inputs use hidden bit 0 with exponent 1.
//     - Tiny results are emitted as subnormals.
//   - Undefined (default): flush-to-zero.
//     - Subnormal inputs are treated as signed zero.
//     - Results below 2^-126 become signed zero.
// TESTING
// - Basic: 0x3F800000 + 0x40000000 (add) -> 0x40400000.
//   0x3F800000 - 0x40000000 (sub) -> 0xBF800000; sign bit set, so the comparator picks B.
// - Equality and cancellation: 0x40400000 - 0x40400000 -> 0x00000000.
//   0x3F800001 - 0x3F800000 -> 0x34000000.
// - Rounding: 0x3F800000 + 0x33800000 -> 0x3F800000 (tie, to even).
//   0x3F800000 + 0x33800001 -> 0x3F800001.
// - Specials: 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
//   0x7F800000 - 0x7F800000 -> 0x7FC00000.
//   0xFFC00001 + 1.0 -> 0x7FC00000.
// - Subnormal: 0x00800000 - 0x00400000 -> 0x00800000 without the macro;
//   -> 0x00400000 with FP_ADD_SUB_SUBNORMAL_EN.
// - Pipeline: 10 back-to-back random ops match the model 3 cycles later, one per cycle.
//   Assert rst_ with 2 in flight -> out_valid=0, S=0 immediately; no stale outputs after release.

Source files
------------

// File: rtl/fp_add_sub_if.sv
// fp_add_sub_if: operand/result bundle for the pipelined FP adder/subtractor
interface fp_add_sub_if #(
  parameter int BIT = 32
);
  logic           in_valid;
  logic [BIT-1:0] A;
  logic [BIT-1:0] B;
  logic           add_or_sub;
  logic [BIT-1:0] S;
  logic           out_valid;
  modport master (output in_valid, A, B, add_or_sub, input S, out_valid);
  modport slave (input in_valid, A, B, add_or_sub, output S, out_valid);
endinterface

// File: rtl/fp_add_sub.sv
// fp_add_sub: pipelined binary32 A+B / A-B, round-to-nearest-even, latency 3.
// Define FP_ADD_SUB_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_add_sub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIT   = 32
) (
  input logic         clk,
  input logic         rst_,
  fp_add_sub_if.slave bus
);
  localparam int SW = MAN_W + 4;
  localparam int LW = $clog2(SW + 1);
  localparam int XW = EXP_W + 1;
  localparam int RW = EXP_W + MAN_W + 1;
  localparam logic [BIT-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic             r_v0, r_op;
  logic [BIT-1:0]   r_a, r_b;
  logic             r_v1, r_sign1, r_sub1, r_spec1;
  logic [EXP_W-1:0] r_e1;
  logic [SW-1:0]    r_x1, r_y1;
  logic [BIT-1:0]   r_sval1;
  logic             r_v2, r_sign2, r_sub2, r_spec2;
  logic [EXP_W-1:0] r_e2;
  logic [SW:0]      r_sum2;
  logic [BIT-1:0]   r_sval2;
  logic             r_ov;
  logic [BIT-1:0]   r_s;
  logic             w_sa, w_sb, w_swap, w_nan, w_inf_a, w_inf_b;
  logic [EXP_W-1:0] w_ea, w_eb, w_d;
  logic [MAN_W:0]   w_ma, w_mb, w_my;
  logic [LW-1:0]    w_sh1;
  logic [2*SW-1:0]  w_wide;
  logic [LW-1:0]    w_lz, w_sh3;
  logic [SW-1:0]    w_m;
  logic [XW-1:0]    w_e3;
  logic             w_tiny, w_up;
  logic [RW-1:0]    w_rnd;
  logic [BIT-1:0]   w_res;
  assign bus.S         = r_s;
  assign bus.out_valid = r_ov;
  // capture operands on in_valid
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      r_v0 <= 1'b0;
      r_op <= 1'b0;
      r_a  <= '0;
      r_b  <= '0;
    end else begin
      r_v0 <= bus.in_valid;
      if (bus.in_valid) begin
        r_op <= bus.add_or_sub;
        r_a  <= bus.A;
        r_b  <= bus.B;
      end
    end
  // stage1 logic: unpack, classify specials, order by magnitude, align smaller operand
  always_comb begin
    w_sa = r_a[BIT-1];
    w_sb = r_b[BIT-1] ^ r_op;
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    w_ea = (r_a[BIT-2:MAN_W] == '0) ? EXP_W'(1) : r_a[BIT-2:MAN_W];
    w_eb = (r_b[BIT-2:MAN_W] == '0) ? EXP_W'(1) : r_b[BIT-2:MAN_W];
    w_ma = {|r_a[BIT-2:MAN_W], r_a[MAN_W-1:0]};
    w_mb = {|r_b[BIT-2:MAN_W], r_b[MAN_W-1:0]};
`else
    w_ea = r_a[BIT-2:MAN_W];
    w_eb = r_b[BIT-2:MAN_W];
    w_ma = (w_ea == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
    w_mb = (w_eb == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
`endif
    w_inf_a = &r_a[BIT-2:MAN_W] & ~|r_a[MAN_W-1:0];
    w_inf_b = &r_b[BIT-2:MAN_W] & ~|r_b[MAN_W-1:0];
    w_nan = (&r_a[BIT-2:MAN_W] & |r_a[MAN_W-1:0]) | (&r_b[BIT-2:MAN_W] & |r_b[MAN_W-1:0]) |
            (w_inf_a & w_inf_b & (w_sa ^ w_sb));
    w_swap = {w_eb, w_mb} > {w_ea, w_ma};
    w_d = w_swap ? w_eb - w_ea : w_ea - w_eb;
    w_sh1 = (w_d > EXP_W'(SW)) ? LW'(SW) : LW'(w_d);
    w_my = w_swap ? w_ma : w_mb;
    w_wide = {w_my, {(SW+3){1'b0}}} >> w_sh1;
  end
  // stage1 register: larger operand, aligned smaller operand with sticky, special result
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      r_v1    <= 1'b0;
      r_sign1 <= 1'b0;
      r_sub1  <= 1'b0;
      r_spec1 <= 1'b0;
      r_e1    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_sval1 <= '0;
    end else begin
      r_v1 <= r_v0;
      if (r_v0) begin
        r_sign1 <= w_swap ? w_sb : w_sa;
        r_sub1  <= w_sa ^ w_sb;
        r_spec1 <= w_nan | w_inf_a | w_inf_b;
        r_e1    <= w_swap ? w_eb : w_ea;
        r_x1    <= {w_swap ? w_mb : w_ma, 3'b000};
        r_y1    <= {w_wide[2*SW-1:SW+1], w_wide[SW] | |w_wide[SW-1:0]};
        r_sval1 <= w_nan ? QNAN : {w_inf_a ? w_sa : w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end
  // stage2 register: significand add/subtract with carry-out
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      r_v2    <= 1'b0;
      r_sign2 <= 1'b0;
      r_sub2  <= 1'b0;
      r_spec2 <= 1'b0;
      r_e2    <= '0;
      r_sum2  <= '0;
      r_sval2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign2 <= r_sign1;
        r_sub2  <= r_sub1;
        r_spec2 <= r_spec1;
        r_e2    <= r_e1;
        r_sum2  <= r_sub1 ? {1'b0, r_x1} - {1'b0, r_y1} : {1'b0, r_x1} + {1'b0, r_y1};
        r_sval2 <= r_sval1;
      end
    end
  // stage3 logic: leading-zero normalize, round to nearest even, pack, specials
  always_comb begin
    w_lz = LW'(SW);
    for (int i = 0; i < SW; i++) if (r_sum2[i]) w_lz = LW'(SW - 1 - i);
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    w_sh3 = ({1'b0, r_e2} > XW'(w_lz)) ? w_lz : LW'(r_e2 - EXP_W'(1));
    w_tiny = 1'b0;
`else
    w_sh3 = w_lz;
    w_tiny = ~r_sum2[SW] & ({1'b0, r_e2} <= XW'(w_lz));
`endif
    w_m = r_sum2[SW] ? {r_sum2[SW:2], |r_sum2[1:0]} : r_sum2[SW-1:0] << w_sh3;
    w_e3 = r_sum2[SW] ? {1'b0, r_e2} + XW'(1) : (w_m[SW-1] ? {1'b0, r_e2} - XW'(w_sh3) : '0);
    w_up = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_rnd = {w_e3, w_m[SW-2:3]} + RW'(w_up);
    w_res = r_spec2 ? r_sval2 :
            (r_sum2 == '0) ? {~r_sub2 & r_sign2, {(BIT-1){1'b0}}} :
            w_tiny ? {r_sign2, {(BIT-1){1'b0}}} :
            (w_rnd[RW-1:MAN_W] >= {1'b0, {EXP_W{1'b1}}}) ? {r_sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
            {r_sign2, w_rnd[RW-2:0]};
  end
  // stage3 register: result holds until the next valid operation arrives
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      r_ov <= 1'b0;
      r_s  <= '0;
    end else begin
      r_ov <= r_v2;
      if (r_v2) r_s <= w_res;
    end
endmodule

// File: tb/tb_fp_add_sub.sv
// tb_fp_add_sub: directed checks of the pipelined FP adder/subtractor
module tb_fp_add_sub;
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int n_err = 0;
  int n_chk = 0;
  always #5 clk = ~clk;
  fp_add_sub_if #(.BIT(32)) bus ();
  fp_add_sub dut (.clk(clk), .rst_(rst_), .bus(bus));
`ifdef FP_ADD_SUB_SUBNORMAL_EN
  localparam logic [31:0] E_SUBN = 32'h00400000;
  localparam logic [31:0] E_TINY = 32'h00000001;
`else
  localparam logic [31:0] E_SUBN = 32'h00800000;
  localparam logic [31:0] E_TINY = 32'h00000000;
`endif
  logic [31:0] ta [10] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h3F800001, 32'h3F800000,
                           32'h3F800000, 32'h7F7FFFFF, 32'h7F800000, 32'hFFC00001, 32'h00800000};
  logic [31:0] tb [10] = '{32'h40000000, 32'h40000000, 32'h40400000, 32'h3F800000, 32'h33800000,
                           32'h33800001, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h00400000};
  logic        to [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] te [10] = '{32'h40400000, 32'hBF800000, 32'h00000000, 32'h34000000, 32'h3F800000,
                           32'h3F800001, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, E_SUBN};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.add_or_sub = op;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk({tag, "_early"}, {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1 chk({tag, "_vld"}, {31'b0, bus.out_valid}, 32'd1);
    chk(tag, bus.S, exp);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.add_or_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_s", bus.S, 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    run_op("add_1p2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    @(posedge clk);
    #1 chk("hold_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("hold_s", bus.S, 32'h40400000);
    run_op("sub_1m2", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000);
    run_op("sub_eq", 32'h40400000, 32'h40400000, 1'b1, 32'h00000000);
    run_op("sub_ulp", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000);
    run_op("rnd_tie", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    run_op("rnd_up", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001);
    run_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    run_op("nan_in", 32'hFFC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    run_op("subn", 32'h00800000, 32'h00400000, 1'b1, E_SUBN);
    run_op("tiny", 32'h00800001, 32'h00800000, 1'b1, E_TINY);
    run_op("nz_add", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    run_op("nz_sub", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000);
    run_op("inf_fin", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000);
    run_op("ninf_m_inf", 32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000);
    run_op("m3_p2", 32'hC0400000, 32'h40000000, 1'b0, 32'hBF800000);
    run_op("2_m1", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (k >= 1) chk($sformatf("pipe_vld%0d", k), {31'b0, bus.out_valid}, (k >= 4 && k < 14) ? 32'd1 : 32'd0);
      if (k >= 4 && k < 14) chk($sformatf("pipe_s%0d", k - 4), bus.S, te[k-4]);
      if (k < 10) begin
        bus.in_valid = 1'b1;
        bus.A = ta[k];
        bus.B = tb[k];
        bus.add_or_sub = to[k];
      end else bus.in_valid = 1'b0;
    end
    run_op("pre_rst", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 32'h3F800000;
    bus.B = 32'h3F800000;
    bus.add_or_sub = 1'b0;
    @(negedge clk);
    bus.A = 32'h40000000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_ = 1'b0;
    #1 chk("midrst_vld", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_s", bus.S, 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_vld%0d", k), {31'b0, bus.out_valid}, 32'd0);
    end
    chk("post_rst_s", bus.S, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
